// File: rtl/trail_pkg.sv
// trail_pkg
// Shared widths, the trail entry layout and the unwinder state encoding used by
// the trail stack and its pop-side controller.
//   VAR_W  variable index width
//   LVL_W  decision-level width
//   LIT_W  literal width, {sign, var}
//   ENT_W  packed trail entry width
package trail_pkg;

    localparam int VAR_W = 16;
    localparam int LVL_W = 16;
    localparam int LIT_W = VAR_W + 1;
    localparam int ENT_W = 1 + LVL_W + LIT_W;

    typedef struct packed {
        logic             is_decision;
        logic [LVL_W-1:0] level;
        logic [LIT_W-1:0] lit;
    } trail_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        UNWIND,
        DONE
    } unwind_state_t;

endpackage

// File: rtl/stack.sv
// stack
// LIFO holding trail entries with a combinational peek of the top entry.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (clears occupancy only)
//   push, push_data  write a new top entry (ignored when full)
//   pop              remove the top entry (ignored when empty)
//   clear            drop all entries
//   top_data         current top entry, zero when empty
//   empty, full      occupancy flags
//   count            number of stored entries
module stack
    import trail_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  trail_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output trail_entry_t top_data,
    output logic         empty,
    output logic         full,
    output logic [CW-1:0] count
);

    trail_entry_t mem [DEPTH];
    logic [CW-1:0] count_q;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    assign top_idx  = AW'(count_q - CW'(1));
    assign wr_idx   = AW'(count_q);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign top_data = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (push && pop) begin
            // Simultaneous push and pop replaces the top; occupancy is unchanged.
            count_q <= count_q;
        end else if (push && !full) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !clear) begin
            if (push && pop) begin
                if (!empty) begin
                    mem[top_idx] <= push_data;
                end
            end else if (push && !full) begin
                mem[wr_idx] <= push_data;
            end
        end
    end

endmodule

// File: rtl/trail_unwinder.sv
// trail_unwinder
// Pop-side controller for the assignment trail. On a backtrack request it pops
// every trail entry whose decision level exceeds the latched target level and
// emits each popped literal as an unassign event over a valid/ready handshake.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           backtrack request, honoured only when idle
//   target_level    level to keep
//   abort           cancel an in-progress unwind
//   busy            high through UNWIND and DONE
//   done            one-cycle completion pulse
//   aborted         qualifies done when the unwind was cancelled
//   popped_count    entries popped by the last unwind
//   stk_top_data    combinational peek of the stack top
//   stk_empty       stack empty flag
//   stk_pop         pop strobe to the stack
//   ua_valid        unassign event valid
//   ua_ready        downstream accepts the event
//   ua_lit          literal being unassigned
module trail_unwinder
    import trail_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LVL_W-1:0] target_level,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] popped_count,
    input  trail_entry_t     stk_top_data,
    input  logic             stk_empty,
    output logic             stk_pop,
    output logic             ua_valid,
    input  logic             ua_ready,
    output logic [LIT_W-1:0] ua_lit
);

    unwind_state_t    state_q;
    unwind_state_t    state_d;
    logic [LVL_W-1:0] target_q;
    logic [CNT_W-1:0] count_q;
    logic             aborted_q;
    logic             need;
    logic             unused_is_decision;

    // The decision flag travels with the entry but plays no part in unwinding.
    assign unused_is_decision = stk_top_data.is_decision;

    // An entry must go while the stack holds something above the kept level.
    assign need = !stk_empty && (stk_top_data.level > target_q);

    assign popped_count = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = UNWIND;
                end
            end
            UNWIND: begin
                if (abort || !need) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Abort suppresses the pop even when the handshake completes in the same cycle.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        aborted  = 1'b0;
        ua_valid = 1'b0;
        stk_pop  = 1'b0;
        ua_lit   = stk_top_data.lit;
        case (state_q)
            UNWIND: begin
                busy     = 1'b1;
                ua_valid = need;
                stk_pop  = need && ua_ready && !abort;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                aborted = aborted_q;
            end
            default: begin
            end
        endcase
    end

    // Target and counter are captured at start; the counter saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q  <= '0;
            count_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_q  <= target_level;
                        count_q   <= '0;
                        aborted_q <= 1'b0;
                    end
                end
                UNWIND: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end
                    if (stk_pop && (count_q != '1)) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trail_unwinder.sv
// tb_trail_unwinder
// Self-checking bench: a stack (DEPTH=8) feeds trail_unwinder; per-cycle
// vector tables cover the plain unwinds and hand-written sequences cover
// abort and reset in the middle of an unwind.
module tb_trail_unwinder;
    import trail_pkg::*;

    localparam int CNT_W = 8;

    typedef struct {
        logic             start;
        logic [LVL_W-1:0] target;
        logic             ready;
        logic             abort;
        logic             busy;
        logic             valid;
        logic [LIT_W-1:0] lit;
        logic             pop;
        logic             done;
        logic             aborted;
        logic [CNT_W-1:0] count;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             stk_rst_n;
    logic             start;
    logic             abort;
    logic             ua_ready;
    logic [LVL_W-1:0] target_level;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             stk_pop;
    logic             ua_valid;
    logic [LIT_W-1:0] ua_lit;
    logic [CNT_W-1:0] popped_count;
    trail_entry_t     stk_top_data;
    trail_entry_t     push_data;
    logic             stk_empty;
    logic             stk_full;
    logic             stk_push;
    logic             stk_clear;
    logic [3:0]       stk_count;

    int checks          = 0;
    int failures        = 0;
    int pop_empty_cnt   = 0;
    int pop_noready_cnt = 0;
    int illegal_cnt     = 0;

    vec_t vecs[$];

    trail_unwinder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .target_level (target_level),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .popped_count (popped_count),
        .stk_top_data (stk_top_data),
        .stk_empty    (stk_empty),
        .stk_pop      (stk_pop),
        .ua_valid     (ua_valid),
        .ua_ready     (ua_ready),
        .ua_lit       (ua_lit)
    );

    stack #(.DEPTH(8)) u_stack (
        .clk       (clk),
        .rst_n     (stk_rst_n),
        .push      (stk_push),
        .push_data (push_data),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .top_data  (stk_top_data),
        .empty     (stk_empty),
        .full      (stk_full),
        .count     (stk_count)
    );

    // Protocol watchers: no pop on empty or without ready, no stack writes while busy.
    always @(negedge clk) begin
        if (stk_pop && stk_empty) pop_empty_cnt++;
        if (stk_pop && !ua_ready) pop_noready_cnt++;
        if (busy && (stk_push || stk_clear)) illegal_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [LVL_W-1:0] lvl, input logic [LIT_W-1:0] lit);
        push_data.is_decision = 1'b0;
        push_data.level       = lvl;
        push_data.lit         = lit;
        stk_push = 1'b1;
        tick();
        stk_push = 1'b0;
    endtask

    task automatic add_vec(input logic st, input logic [LVL_W-1:0] tg, input logic rd, input logic ab,
                           input logic b, input logic v, input logic [LIT_W-1:0] l, input logic p,
                           input logic d, input logic a, input logic [CNT_W-1:0] c);
        vec_t t;
        t.start = st; t.target = tg; t.ready = rd; t.abort = ab;
        t.busy = b; t.valid = v; t.lit = l; t.pop = p;
        t.done = d; t.aborted = a; t.count = c;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        start        = v.start;
        target_level = v.target;
        ua_ready     = v.ready;
        abort        = v.abort;
    endtask

    task automatic run_vectors(input string name, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("%s[%0d].busy", name, i - lo), busy, vecs[i].busy);
            checkOutput($sformatf("%s[%0d].valid", name, i - lo), ua_valid, vecs[i].valid);
            if (vecs[i].valid)
                checkOutput($sformatf("%s[%0d].lit", name, i - lo), ua_lit, vecs[i].lit);
            checkOutput($sformatf("%s[%0d].pop", name, i - lo), stk_pop, vecs[i].pop);
            checkOutput($sformatf("%s[%0d].done", name, i - lo), done, vecs[i].done);
            checkOutput($sformatf("%s[%0d].aborted", name, i - lo), aborted, vecs[i].aborted);
            checkOutput($sformatf("%s[%0d].count", name, i - lo), popped_count, vecs[i].count);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int t1_lo, t2_lo, t3_lo, t4_lo, t4_hi;
        int n;
        logic seen_done;

        rst_n = 1'b0; stk_rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; ua_ready = 1'b0; target_level = '0;
        stk_push = 1'b0; stk_clear = 1'b0; push_data = '0;

        // Test 1: target 1, ready high; target input changes after start to prove latching.
        //        st tg rd ab  b  v  lit    p  d  a  cnt
        t1_lo = vecs.size();
        add_vec(1, 1, 1, 0,  0, 0, 17'h0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0,  1, 1, 17'h6, 1, 0, 0, 0);
        add_vec(0, 0, 1, 0,  1, 1, 17'h5, 1, 0, 0, 1);
        add_vec(0, 0, 1, 0,  1, 1, 17'h4, 1, 0, 0, 2);
        add_vec(0, 0, 1, 0,  1, 0, 17'h0, 0, 0, 0, 3);
        add_vec(0, 0, 1, 0,  1, 0, 17'h0, 0, 1, 0, 3);
        add_vec(0, 0, 1, 0,  0, 0, 17'h0, 0, 0, 0, 3);
        // Test 2: ready toggling; start while busy is ignored; count holds until start.
        t2_lo = vecs.size();
        add_vec(1, 1, 0, 0,  0, 0, 17'h0, 0, 0, 0, 3);
        add_vec(0, 0, 1, 0,  1, 1, 17'h6, 1, 0, 0, 0);
        add_vec(1, 0, 0, 0,  1, 1, 17'h5, 0, 0, 0, 1);
        add_vec(0, 0, 1, 0,  1, 1, 17'h5, 1, 0, 0, 1);
        add_vec(0, 0, 0, 0,  1, 1, 17'h4, 0, 0, 0, 2);
        add_vec(0, 0, 1, 0,  1, 1, 17'h4, 1, 0, 0, 2);
        add_vec(0, 0, 0, 0,  1, 0, 17'h0, 0, 0, 0, 3);
        add_vec(0, 0, 1, 0,  1, 0, 17'h0, 0, 1, 0, 3);
        add_vec(0, 0, 0, 0,  0, 0, 17'h0, 0, 0, 0, 3);
        // Test 3: target above top level; abort in DONE and IDLE has no effect.
        t3_lo = vecs.size();
        add_vec(1, 5, 1, 0,  0, 0, 17'h0, 0, 0, 0, 3);
        add_vec(0, 5, 1, 0,  1, 0, 17'h0, 0, 0, 0, 0);
        add_vec(0, 5, 1, 1,  1, 0, 17'h0, 0, 1, 0, 0);
        add_vec(0, 5, 1, 1,  0, 0, 17'h0, 0, 0, 0, 0);
        add_vec(0, 5, 1, 0,  0, 0, 17'h0, 0, 0, 0, 0);
        // Test 4: empty stack, target 0.
        t4_lo = vecs.size();
        add_vec(1, 0, 1, 0,  0, 0, 17'h0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0,  1, 0, 17'h0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0,  1, 0, 17'h0, 0, 1, 0, 0);
        add_vec(0, 0, 1, 0,  0, 0, 17'h0, 0, 0, 0, 0);
        t4_hi = vecs.size();

        tick();
        tick();
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.aborted", aborted, 0);
        checkOutput("reset.valid", ua_valid, 0);
        checkOutput("reset.pop", stk_pop, 0);
        checkOutput("reset.count", popped_count, 0);
        checkOutput("reset.stk_empty", stk_empty, 1);
        checkOutput("reset.stk_full", stk_full, 0);
        rst_n = 1'b1;
        stk_rst_n = 1'b1;

        push_entry(1, 17'h2);
        push_entry(1, 17'h3);
        push_entry(2, 17'h4);
        push_entry(3, 17'h5);
        push_entry(3, 17'h6);
        checkOutput("t1.stk_count_before", stk_count, 5);
        run_vectors("t1", t1_lo, t2_lo);
        checkOutput("t1.top_lit", stk_top_data.lit, 17'h3);
        checkOutput("t1.stk_count", stk_count, 2);

        push_entry(2, 17'h4);
        push_entry(3, 17'h5);
        push_entry(3, 17'h6);
        run_vectors("t2", t2_lo, t3_lo);
        checkOutput("t2.top_lit", stk_top_data.lit, 17'h3);
        checkOutput("t2.stk_count", stk_count, 2);

        push_entry(2, 17'h4);
        push_entry(3, 17'h5);
        push_entry(3, 17'h6);
        run_vectors("t3", t3_lo, t4_lo);
        checkOutput("t3.stk_count", stk_count, 5);
        checkOutput("t3.top_lit", stk_top_data.lit, 17'h6);

        stk_clear = 1'b1;
        tick();
        stk_clear = 1'b0;
        checkOutput("t4.stk_empty_before", stk_empty, 1);
        run_vectors("t4", t4_lo, t4_hi);
        checkOutput("t4.stk_empty_after", stk_empty, 1);

        // Test 5: abort in the same cycle as the second handshake.
        for (int k = 0; k < 5; k++) push_entry(4, LIT_W'(17'h10 + k));
        target_level = 0; ua_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("t5.c1.valid", ua_valid, 1);
        checkOutput("t5.c1.lit", ua_lit, 17'h14);
        checkOutput("t5.c1.pop", stk_pop, 1);
        tick();
        abort = 1'b1;
        @(negedge clk);
        checkOutput("t5.c2.valid", ua_valid, 1);
        checkOutput("t5.c2.lit", ua_lit, 17'h13);
        checkOutput("t5.c2.pop", stk_pop, 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t5.c3.done", done, 1);
        checkOutput("t5.c3.aborted", aborted, 1);
        checkOutput("t5.c3.count", popped_count, 1);
        tick();
        checkOutput("t5.c4.busy", busy, 0);
        checkOutput("t5.c4.done", done, 0);
        checkOutput("t5.c4.aborted", aborted, 0);
        checkOutput("t5.c4.count", popped_count, 1);
        checkOutput("t5.stk_count", stk_count, 4);

        // Test 6: reset mid-unwind with ready low, then a full unwind.
        ua_ready = 1'b0; target_level = 0; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("t6.pre.valid", ua_valid, 1);
        checkOutput("t6.pre.lit", ua_lit, 17'h13);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t6.rst.busy", busy, 0);
        checkOutput("t6.rst.valid", ua_valid, 0);
        checkOutput("t6.rst.pop", stk_pop, 0);
        seen_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            tick();
        end
        checkOutput("t6.rst.no_done", seen_done, 0);
        checkOutput("t6.rst.stk_count", stk_count, 4);

        ua_ready = 1'b1; target_level = 0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            @(negedge clk);
            if (stk_pop) begin
                checkOutput($sformatf("t6.run.lit%0d", n), ua_lit, 32'h13 - 32'(n));
                n++;
            end
            if (done) begin
                seen_done = 1'b1;
                checkOutput("t6.run.count", popped_count, 4);
                checkOutput("t6.run.aborted", aborted, 0);
            end
            tick();
        end
        checkOutput("t6.run.done_seen", seen_done, 1);
        checkOutput("t6.run.pops", n, 4);
        checkOutput("t6.run.stk_empty", stk_empty, 1);

        checkOutput("mon.pop_on_empty", pop_empty_cnt, 0);
        checkOutput("mon.pop_without_ready", pop_noready_cnt, 0);
        checkOutput("mon.stack_write_while_busy", illegal_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
